// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants and types for seven-segment pattern handling.
// Segment patterns are active-low, bit order [6:0] = g f e d c b a.
package seg7_pkg;

  // All segments off.
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Pattern for each hex digit; the entry index is the digit value.
  localparam logic [6:0] DIGIT_PAT [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  // LOCKED: current pattern already handled; SETTLING: waiting for it to hold.
  typedef enum logic {
    LOCKED   = 1'b0,
    SETTLING = 1'b1
  } sync_state_e;

endpackage

// File: rtl/seg7_pattern_decode.sv
// seg7_pattern_decode: combinational classifier for a 7-bit active-low
// segment pattern. Reports whether it is a hex digit (and which one) or blank.
// A pattern that is neither is illegal.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] pattern_i,
  output logic       is_digit_o,
  output logic       is_blank_o,
  output logic [3:0] digit_o
);

  // Search the digit table; patterns are unique so at most one entry matches.
  always_comb begin
    is_digit_o = 1'b0;
    digit_o    = 4'd0;
    is_blank_o = (pattern_i == SEG_BLANK);
    for (int i = 0; i < 16; i++) begin
      is_digit_o = is_digit_o | (pattern_i == DIGIT_PAT[i]);
      digit_o    = (pattern_i == DIGIT_PAT[i]) ? 4'(i) : digit_o;
    end
  end

endmodule

// File: rtl/hex_segment_decoder.sv
// hex_segment_decoder: samples an active-low segment bus, waits for the
// pattern to hold for STABLE_CYCLES further edges, then decodes it to a hex
// digit, flags blank, or flags an illegal pattern.
// Build option: define SEGDEC_ERRCNT_EN to build the saturating illegal
// pattern counter; otherwise err_count is tied to zero.
module hex_segment_decoder
  import seg7_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] seg_in,
  output logic [3:0] data_out,
  output logic       data_valid,
  output logic       data_blank,
  output logic       bad_pattern,
  output logic [7:0] err_count
);

  localparam logic [7:0] CNT_LAST = 8'(STABLE_CYCLES - 1);

  sync_state_e state_q, state_d;
  logic [6:0]  seg_q, seg_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [3:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        blank_q, blank_d;
  logic        bad_q, bad_d;
  logic        accept_s;
  logic        is_digit_s;
  logic        is_blank_s;
  logic [3:0]  digit_s;

  seg7_pattern_decode u_decode (
    .pattern_i  (seg_q),
    .is_digit_o (is_digit_s),
    .is_blank_o (is_blank_s),
    .digit_o    (digit_s)
  );

  // Stability FSM: restart on any change, accept once the count completes.
  always_comb begin
    seg_d    = seg_q;
    cnt_d    = cnt_q;
    state_d  = state_q;
    accept_s = 1'b0;
    if (seg_in != seg_q) begin
      seg_d   = seg_in;
      cnt_d   = 8'd0;
      state_d = SETTLING;
    end else if (state_q == SETTLING) begin
      if (cnt_q == CNT_LAST) begin
        accept_s = 1'b1;
        state_d  = LOCKED;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Output next-state: pulses default low, levels held unless accepted.
  always_comb begin
    data_d  = data_q;
    blank_d = blank_q;
    valid_d = 1'b0;
    bad_d   = 1'b0;
    if (accept_s) begin
      if (is_digit_s) begin
        data_d  = digit_s;
        valid_d = 1'b1;
        blank_d = 1'b0;
      end else if (is_blank_s) begin
        blank_d = 1'b1;
      end else begin
        bad_d = 1'b1;
      end
    end else begin
      bad_d = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= LOCKED;
      seg_q   <= SEG_BLANK;
      cnt_q   <= 8'd0;
      data_q  <= 4'd0;
      valid_q <= 1'b0;
      blank_q <= 1'b1;
      bad_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      seg_q   <= seg_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      blank_q <= blank_d;
      bad_q   <= bad_d;
    end
  end

`ifdef SEGDEC_ERRCNT_EN
  logic [7:0] err_q, err_d;

  // Saturating count of accepted illegal patterns.
  always_comb begin
    err_d = err_q;
    if (bad_d && (err_q != 8'hFF)) begin
      err_d = err_q + 8'd1;
    end else begin
      err_d = err_q;
    end
  end

  // Error counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= 8'd0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_count = err_q;
`else
  assign err_count = 8'd0;
`endif

  assign data_out    = data_q;
  assign data_valid  = valid_q;
  assign data_blank  = blank_q;
  assign bad_pattern = bad_q;

endmodule

// File: tb/tb_hex_segment_decoder.sv
// Self-checking bench for hex_segment_decoder: directed scenarios followed by
// random pattern/hold sequences, all compared every cycle against a
// run-length based reference model.
module tb_hex_segment_decoder;

  localparam int S = 4;

  logic       clk;
  logic       reset;
  logic [6:0] seg_in;
  logic [3:0] data_out;
  logic       data_valid;
  logic       data_blank;
  logic       bad_pattern;
  logic [7:0] err_count;

  hex_segment_decoder #(.STABLE_CYCLES(S)) dut (
    .clk         (clk),
    .reset       (reset),
    .seg_in      (seg_in),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .data_blank  (data_blank),
    .bad_pattern (bad_pattern),
    .err_count   (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference digit table, written out from the legal pattern list.
  logic [6:0] tb_pat [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  int errors = 0;
  int checks = 0;
  int vcount = 0;
  int bcount = 0;

  // Reference model state.
  logic [6:0] m_seg;
  int         m_run;
  bit         m_armed;
  logic [3:0] m_out;
  bit         m_valid;
  bit         m_blank;
  bit         m_bad;
  int         m_err;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int lookup(input logic [6:0] x);
    for (int i = 0; i < 16; i++) begin
      if (x == tb_pat[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_seg = 7'h7F; m_run = 0; m_armed = 0;
    m_out = 4'd0; m_valid = 0; m_blank = 1; m_bad = 0; m_err = 0;
  endtask

  // A pattern is accepted once it has been seen on S+1 consecutive edges,
  // once per appearance.
  task automatic model_edge(input logic [6:0] x);
    int idx;
    m_valid = 0;
    m_bad   = 0;
    if (x != m_seg) begin
      m_seg = x; m_run = 1; m_armed = 1;
    end else begin
      m_run++;
      if (m_armed && m_run == S + 1) begin
        m_armed = 0;
        idx = lookup(x);
        if (idx >= 0) begin
          m_out = 4'(idx); m_valid = 1; m_blank = 0;
        end else if (x == 7'h7F) begin
          m_blank = 1;
        end else begin
          m_bad = 1;
          if (m_err < 255) m_err++;
        end
      end
    end
  endtask

  function automatic int exp_err();
`ifdef SEGDEC_ERRCNT_EN
    return m_err;
`else
    return 0;
`endif
  endfunction

  task automatic compare_all();
    check("data_out", int'(data_out), int'(m_out));
    check("data_valid", int'(data_valid), int'(m_valid));
    check("data_blank", int'(data_blank), int'(m_blank));
    check("bad_pattern", int'(bad_pattern), int'(m_bad));
    check("err_count", int'(err_count), exp_err());
  endtask

  task automatic step(input logic [6:0] x);
    seg_in = x;
    @(posedge clk);
    model_edge(x);
    #1;
    if (data_valid) vcount++;
    if (bad_pattern) bcount++;
    compare_all();
  endtask

  task automatic hold(input logic [6:0] x, input int n);
    for (int i = 0; i < n; i++) step(x);
  endtask

  int v0;
  int b0;

  initial begin
    reset  = 1'b1;
    seg_in = 7'h7F;
    model_reset();
    #12;
    compare_all();
    @(negedge clk);
    reset = 1'b0;

    // Held blank after reset: nothing happens.
    v0 = vcount; b0 = bcount;
    hold(7'h7F, 20);
    check("blank_idle_valid", vcount - v0, 0);
    check("blank_idle_bad", bcount - b0, 0);
    check("blank_idle_level", int'(data_blank), 1);

    // Digit 3 held 6 edges: one pulse after the 5th edge.
    v0 = vcount;
    hold(7'b0110000, 4);
    check("d3_early", vcount - v0, 0);
    step(7'b0110000);
    check("d3_pulse", int'(data_valid), 1);
    step(7'b0110000);
    check("d3_count", vcount - v0, 1);
    check("d3_out", int'(data_out), 3);
    check("d3_blank", int'(data_blank), 0);

    // F for 3 edges, then E held.
    v0 = vcount;
    hold(7'b0001110, 3);
    hold(7'b0000110, 4);
    check("fe_none", vcount - v0, 0);
    step(7'b0000110);
    check("e_pulse", int'(data_valid), 1);
    hold(7'b0000110, 2);
    check("fe_count", vcount - v0, 1);
    check("e_out", int'(data_out), 14);

    // Illegal pattern.
    b0 = bcount;
    hold(7'b1010101, 7);
    check("ill_pulses", bcount - b0, 1);
    check("ill_out", int'(data_out), 14);
`ifdef SEGDEC_ERRCNT_EN
    check("ill_err", int'(err_count), 1);
`else
    check("ill_err", int'(err_count), 0);
`endif

    // Saturation: 300 illegal/blank alternations.
    for (int i = 0; i < 300; i++) begin
      hold(7'b1010101, S + 1);
      hold(7'h7F, S + 1);
    end
`ifdef SEGDEC_ERRCNT_EN
    check("err_sat", int'(err_count), 255);
`else
    check("err_sat", int'(err_count), 0);
`endif

    // Glitch away from a locked 2 and back.
    hold(7'b0100100, 6);
    v0 = vcount;
    step(7'b1111001);
    hold(7'b0100100, 6);
    check("glitch_count", vcount - v0, 1);
    check("glitch_out", int'(data_out), 2);

    // Reset in the middle of settling on 9.
    hold(7'b0010000, 2);
    reset = 1'b1;
    #2;
    model_reset();
    compare_all();
    seg_in = 7'h7F;
    @(posedge clk);
    @(posedge clk);
    #3;
    reset = 1'b0;
    v0 = vcount;
    hold(7'h7F, 20);
    check("rst_no_valid", vcount - v0, 0);
    check("rst_out", int'(data_out), 0);
    check("rst_blank", int'(data_blank), 1);

    // Random pattern/hold sequences.
    for (int k = 0; k < 300; k++) begin
      logic [6:0] p;
      int sel;
      sel = int'($urandom_range(0, 99));
      if (sel < 60) p = tb_pat[$urandom_range(0, 15)];
      else if (sel < 75) p = 7'h7F;
      else p = 7'($urandom);
      hold(p, int'($urandom_range(1, 7)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hex_segment_decoder.md
# hex_segment_decoder

Receive-side counterpart of the hex-to-seven-segment driver: samples an active-low 7-bit segment bus, waits for the pattern to hold stable, and decodes it back to a 4-bit hex digit. Flags blank (all-off) and illegal patterns, and counts illegal patterns. Used as an on-chip checker for display outputs and as a front end when segment patterns arrive from another board.

## Interface
Parameters:
- STABLE_CYCLES, default 4: consecutive cycles (after the first) a pattern must hold before it is accepted; legal range 1..255.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high.
- seg_in  in  7  segment bus, active-low; bit order [6:0] = g f e d c b a.
- data_out  out  4  last accepted hex digit.
- data_valid  out  1  one-cycle pulse when a legal digit is accepted.
- data_blank  out  1  level; high while the last accepted pattern is 7'b1111111.
- bad_pattern  out  1  one-cycle pulse when an illegal pattern is accepted.
- err_count  out  8  saturating count of accepted illegal patterns.

## Operation
- Legal patterns:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, B=0000011, C=1000110, D=0100001, E=0000110, F=0001110
  - blank=1111111. Every other pattern is illegal.
- Registers: seg_q (7b), stability counter cnt (8b), state ∈ {LOCKED, SETTLING}.
- Every edge:
  - seg_in != seg_q: seg_q <= seg_in, cnt <= 0, state <= SETTLING.
  - seg_in == seg_q, state is SETTLING, cnt < STABLE_CYCLES-1: cnt <= cnt+1.
  - seg_in == seg_q, state is SETTLING, cnt == STABLE_CYCLES-1: accept, state <= LOCKED.
- Accept, by decode of seg_q:
  - Digit: data_out <= digit, data_valid <= 1, data_blank <= 0.
  - Blank: data_blank <= 1; data_out is held; no pulse.
  - Illegal: bad_pattern <= 1, err_count <= err_count+1, saturating at 255; data_out and data_blank are held.
- LOCKED: no further acceptance until seg_in changes.
- A change during SETTLING restarts settling from cnt=0. A glitch away from the locked pattern and back re-accepts it and pulses again.
- data_valid and bad_pattern are cleared on every edge that does not accept.

## Timing
- Reset values: data_out=0, data_valid=0, data_blank=1, bad_pattern=0, err_count=0, seg_q=7'b1111111, cnt=0, state=LOCKED.
- A held blank input after reset therefore produces no acceptance.
- Latency: new pattern P is present at edge N, where seg_q captures P. It is accepted at edge N+STABLE_CYCLES. Outputs are registered and visible in the cycle after that edge.
- P must be present at STABLE_CYCLES+1 consecutive edges to be accepted.
- With STABLE_CYCLES=1, acceptance is at edge N+1.
- Reset asserted mid-settle: everything returns to reset values immediately. Any pending acceptance is discarded.
- Acceptance and a new input change at the same edge cannot both happen: a change at that edge means seg_in != seg_q, so no accept.

## Configuration
- SEGDEC_ERRCNT_EN defined: err_count increments on each illegal accept, saturating at 255.
- SEGDEC_ERRCNT_EN undefined: the counter register is not built and err_count is driven to constant 0. bad_pattern still pulses.

## Structure
- Package seg7_pkg holds:
  - the 16 digit pattern constants as a 16-entry array;
  - SEG_BLANK = 7'b1111111;
  - the state enum {LOCKED, SETTLING}.
- Sub-module seg7_pattern_decode: purely combinational; 7-bit pattern in, {is_digit, is_blank, digit[3:0]} out. It is shared with future display checkers.
- The top holds the sync/stability FSM and the output registers.

## Test plan
- Reset with seg_in=1111111, STABLE_CYCLES=4 -> no pulses for 20 cycles; data_blank=1, data_out=0.
- Apply 0110000 (3), held 6 edges -> data_valid pulses exactly once, after the 5th edge; data_out=3, data_blank=0.
- Apply 0001110 (F) for 3 edges, then 0000110 (E) held -> no pulse for F; E accepted 5 edges after its first edge; data_out=E.
- Apply illegal 1010101 held -> bad_pattern pulses once; err_count=1; data_out unchanged. Repeat 300 illegal/blank alternations -> err_count=255 (0 with macro undefined).
- Locked on 2, one-cycle glitch to 1111001, then back to 2 -> 1 is not accepted; 2 is re-accepted with one more data_valid pulse.
- Assert reset 2 edges into settling on 9 -> all outputs return to reset values; no data_valid pulse after release while seg_in stays 1111111.
